// File: rtl/lsu_pkg.sv
// Shared definitions for the MIPS32 load/store access controller.
// Opcodes, status codes and controller state encoding.
package lsu_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ACCESS,
    DONE
  } state_e;

  function automatic logic [31:0] sext16(
    input logic [15:0] v
  );
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Opcode size/sign decode, alignment check, byte-lane
// steering for stores and lane extraction for loads.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  ea_lo,
  input  logic [31:0] rt,
  input  logic [31:0] rdata,
  output logic        illegal,
  output logic        misaligned,
  output logic        is_store,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);

  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic        sgn;
  logic [31:0] shifted;

  assign is_b = (opcode == OP_LB)
              | (opcode == OP_LBU)
              | (opcode == OP_SB);
  assign is_h = (opcode == OP_LH)
              | (opcode == OP_LHU)
              | (opcode == OP_SH);
  assign is_w = (opcode == OP_LW)
              | (opcode == OP_SW);

  assign is_store = (opcode == OP_SB)
                  | (opcode == OP_SH)
                  | (opcode == OP_SW);
  assign sgn      = (opcode == OP_LB)
                  | (opcode == OP_LH);

  assign illegal    = ~(is_b | is_h | is_w);
  assign misaligned = (is_h & ea_lo[0])
                    | (is_w & (|ea_lo));

  // Bring the addressed lane down to bit 0.
  assign shifted = rdata >> {ea_lo, 3'b000};

  always_comb begin
    be    = '0;
    wdata = '0;
    ldata = '0;
    unique case (1'b1)
      is_b: begin
        be    = 4'b0001 << ea_lo;
        wdata = {4{rt[7:0]}};
        ldata = {{24{sgn & shifted[7]}},
                 shifted[7:0]};
      end
      is_h: begin
        be    = 4'b0011 << ea_lo;
        wdata = {2{rt[15:0]}};
        ldata = {{16{sgn & shifted[15]}},
                 shifted[15:0]};
      end
      is_w: begin
        be    = 4'b1111;
        wdata = rt;
        ldata = rdata;
      end
      default: ;
    endcase
    if (is_store) begin
      ldata = '0;
    end else begin
      wdata = '0;
    end
  end

endmodule

// File: rtl/lsu_access_ctrl.sv
// Load/store sequencing controller: EA formation, alignment,
// single-port memory handshake with timeout, result return.
module lsu_access_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [31:0] req_rs,
  input  logic [31:0] req_rt,
  input  logic [15:0] req_imm,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        done,
  output logic [31:0] load_data,
  output logic [1:0]  err
);

  state_e             state_q, state_d;
  logic [5:0]         op_q, op_d;
  logic [31:0]        rs_q, rs_d;
  logic [31:0]        rt_q, rt_d;
  logic [15:0]        imm_q, imm_d;
  logic [31:0]        ea_q, ea_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        ld_q, ld_d;
  logic [1:0]         err_q, err_d;

  logic [31:0] ea_sum;
  logic [1:0]  ea_lo;
  logic        accept;
  logic        timeout_hit;
  logic        illegal;
  logic        misaligned;
  logic        is_store;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] ldata;

  assign ea_sum = rs_q + sext16(imm_q);
  // Alignment is judged in CALC before EA is registered.
  assign ea_lo  = (state_q == CALC) ? ea_sum[1:0]
                                    : ea_q[1:0];
  assign accept = req_valid & (state_q == IDLE);
  assign timeout_hit =
    (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  lsu_lane_align u_align (
    .opcode     (op_q),
    .ea_lo      (ea_lo),
    .rt         (rt_q),
    .rdata      (mem_rdata),
    .illegal    (illegal),
    .misaligned (misaligned),
    .is_store   (is_store),
    .be         (be),
    .wdata      (wdata),
    .ldata      (ldata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      imm_q   <= '0;
      ea_q    <= '0;
      cnt_q   <= '0;
      ld_q    <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      imm_q   <= imm_d;
      ea_q    <= ea_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = CALC;
      end
      CALC: begin
        if (illegal | misaligned) state_d = DONE;
        else                      state_d = ACCESS;
      end
      ACCESS: begin
        if (mem_ack | timeout_hit) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_d  = op_q;
    rs_d  = rs_q;
    rt_d  = rt_q;
    imm_d = imm_q;
    ea_d  = ea_q;
    cnt_d = cnt_q;
    ld_d  = ld_q;
    err_d = err_q;
    if (accept) begin
      op_d  = req_opcode;
      rs_d  = req_rs;
      rt_d  = req_rt;
      imm_d = req_imm;
    end
    if (state_q == CALC) begin
      ea_d  = ea_sum;
      cnt_d = '0;
      if (illegal) begin
        ld_d  = '0;
        err_d = ERR_ILLEGAL;
      end else if (misaligned) begin
        ld_d  = '0;
        err_d = ERR_ALIGN;
      end
    end
    // A late ack on the final cycle still completes.
    if (state_q == ACCESS) begin
      if (mem_ack) begin
        ld_d  = ldata;
        err_d = ERR_OK;
      end else if (timeout_hit) begin
        ld_d  = '0;
        err_d = ERR_TIMEOUT;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    mem_req   = (state_q == ACCESS);
    mem_we    = mem_req & is_store;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    if (mem_req) begin
      mem_addr  = {ea_q[31:2], 2'b00};
      mem_be    = be;
      mem_wdata = wdata;
    end
    done      = (state_q == DONE);
    load_data = ld_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_lsu_access_ctrl.sv
// Directed and randomized transactions against a
// byte-lane reference model of the load/store controller.
module tb_lsu_access_ctrl;
  import lsu_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_opcode;
  logic [31:0] req_rs;
  logic [31:0] req_rt;
  logic [15:0] req_imm;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        done;
  logic [31:0] load_data;
  logic [1:0]  err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lsu_access_ctrl #(
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_rs     (req_rs),
    .req_rt     (req_rt),
    .req_imm    (req_imm),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .done       (done),
    .load_data  (load_data),
    .err        (err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic int op_size(input logic [5:0] op);
    case (op)
      6'h20, 6'h24, 6'h28: return 1;
      6'h21, 6'h25, 6'h29: return 2;
      6'h23, 6'h2b:        return 4;
      default:             return 0;
    endcase
  endfunction

  function automatic bit op_store(input logic [5:0] op);
    return op == 6'h28 || op == 6'h29 || op == 6'h2b;
  endfunction

  function automatic bit op_signed(input logic [5:0] op);
    return op == 6'h20 || op == 6'h21;
  endfunction

  // ack_at < 0 means never acknowledge.
  task automatic run(input string nm,
                     input logic [5:0]  op,
                     input logic [31:0] rs,
                     input logic [31:0] rt,
                     input logic [15:0] imm,
                     input int          ack_at,
                     input logic [31:0] rdata);
    logic [31:0] ea;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic [31:0] eld;
    logic [1:0]  eerr;
    longint      v;
    longint      m;
    int          sz;
    int          lo;
    int          reqcyc;
    bit          got;
    bit          tmo;
    sz  = op_size(op);
    ea  = rs + {16'h0, imm};
    if (imm[15]) ea = ea - 32'h0001_0000;
    lo  = int'(ea % 4);
    tmo = (ack_at < 0) || (ack_at >= TO);
    ebe = '0;
    ewd = '0;
    eld = '0;
    for (int n = 0; n < 4; n++) begin
      if (sz > 0 && n >= lo && n < lo + sz) ebe[n] = 1'b1;
      if (op_store(op))
        ewd[8*n +: 8] = rt[8*(n % sz) +: 8];
    end
    if (sz > 0 && !op_store(op)) begin
      m = longint'(1) << (8 * sz);
      v = longint'(rdata >> (8 * lo)) % m;
      if (op_signed(op) && v >= m / 2) v = v - m;
      eld = v[31:0];
    end
    if (sz == 0)            eerr = 2'b10;
    else if (lo % sz != 0)  eerr = 2'b01;
    else if (tmo)           eerr = 2'b11;
    else                    eerr = 2'b00;
    if (eerr != 2'b00) eld = '0;

    @(negedge clk);
    chk({nm, ".ready"}, 32'(req_ready), 1);
    req_valid  = 1'b1;
    req_opcode = op;
    req_rs     = rs;
    req_rt     = rt;
    req_imm    = imm;
    @(negedge clk);
    req_valid  = 1'b0;
    req_opcode = 6'($urandom);
    req_rs     = $urandom;
    req_rt     = $urandom;
    req_imm    = 16'($urandom);
    chk({nm, ".calc_ready"}, 32'(req_ready), 0);
    chk({nm, ".calc_req"}, 32'(mem_req), 0);
    chk({nm, ".calc_done"}, 32'(done), 0);
    @(negedge clk);
    if (eerr == 2'b01 || eerr == 2'b10) begin
      chk({nm, ".err_req"}, 32'(mem_req), 0);
    end else begin
      reqcyc = 0;
      got    = 1'b0;
      for (int k = 0; k < TO && !got; k++) begin
        chk({nm, ".req"}, 32'(mem_req), 1);
        chk({nm, ".addr"}, mem_addr, ea & 32'hFFFF_FFFC);
        chk({nm, ".be"}, 32'(mem_be), 32'(ebe));
        chk({nm, ".we"}, 32'(mem_we),
            32'(op_store(op)));
        chk({nm, ".wdata"}, mem_wdata, ewd);
        chk({nm, ".wait_done"}, 32'(done), 0);
        reqcyc++;
        if (k == ack_at) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata;
          got       = 1'b1;
        end else begin
          mem_rdata = $urandom;
        end
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
      chk({nm, ".reqcyc"}, 32'(reqcyc),
          32'(tmo ? TO : ack_at + 1));
      chk({nm, ".done_req"}, 32'(mem_req), 0);
    end
    chk({nm, ".done"}, 32'(done), 1);
    chk({nm, ".err"}, 32'(err), 32'(eerr));
    if (eerr != 2'b01 && eerr != 2'b10)
      chk({nm, ".ldata"}, load_data, eld);
    @(negedge clk);
    chk({nm, ".post_done"}, 32'(done), 0);
    chk({nm, ".post_ready"}, 32'(req_ready), 1);
    chk({nm, ".hold_err"}, 32'(err), 32'(eerr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [10];
    logic [5:0] rop;
    logic [31:0] rrs;
    ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
            6'h28, 6'h29, 6'h2b, 6'h15, 6'h3f};
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_opcode = '0;
    req_rs     = '0;
    req_rt     = '0;
    req_imm    = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    #2;
    chk("rst.ready", 32'(req_ready), 1);
    chk("rst.req", 32'(mem_req), 0);
    chk("rst.we", 32'(mem_we), 0);
    chk("rst.addr", mem_addr, 0);
    chk("rst.be", 32'(mem_be), 0);
    chk("rst.wdata", mem_wdata, 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.ldata", load_data, 0);
    chk("rst.err", 32'(err), 0);
    @(negedge clk);
    reset_n = 1'b1;

    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray_ack.done", 32'(done), 0);
    chk("stray_ack.ready", 32'(req_ready), 1);

    run("lw", OP_LW, 32'h0000_1000, 0, 16'hFFFC,
        0, 32'hDEAD_BEEF);
    run("lb", OP_LB, 32'h0000_1000, 0, 16'h0003,
        0, 32'h8012_3456);
    run("lbu", OP_LBU, 32'h0000_1000, 0, 16'h0003,
        0, 32'h8012_3456);
    run("sh", OP_SH, 32'h0000_2000, 32'h1234_ABCD,
        16'h0002, 1, 32'h5555_5555);
    run("lh_mis", OP_LH, 32'h0000_2000, 0, 16'h0001,
        0, 32'h0);
    run("sw_mis", OP_SW, 32'h0000_2000, 1, 16'h0002,
        0, 32'h0);
    run("illegal", 6'h15, 32'h0000_2000, 0, 16'h0000,
        0, 32'h0);
    run("sw_to", OP_SW, 32'h0000_3000, 32'hCAFE_F00D,
        16'h0010, -1, 32'h0);
    run("lw_after_to", OP_LW, 32'h0000_3000, 0,
        16'h0010, 0, 32'h0BAD_CAFE);
    run("lh_lastack", OP_LH, 32'h0000_4000, 0,
        16'h0002, TO - 1, 32'hF00F_1234);
    run("lhu_wrap", OP_LHU, 32'hFFFF_FFFC, 0,
        16'h0008, 2, 32'h8001_7FFE);
    run("sb", OP_SB, 32'h0000_5001, 32'h0000_00A5,
        16'h0000, 0, 32'h0);

    @(negedge clk);
    req_valid  = 1'b1;
    req_opcode = OP_SW;
    req_rs     = 32'h0000_6000;
    req_rt     = 32'h1111_2222;
    req_imm    = 16'h0000;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst.req_before", 32'(mem_req), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst.req", 32'(mem_req), 0);
    chk("mid_rst.ready", 32'(req_ready), 1);
    chk("mid_rst.done", 32'(done), 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst.no_done", 32'(done), 0);
    end
    run("lw_after_rst", OP_LW, 32'h0000_7000, 0,
        16'h0004, 1, 32'h1357_9BDF);

    for (int i = 0; i < 40; i++) begin
      rop = ops[$urandom_range(0, 9)];
      rrs = $urandom;
      if ($urandom_range(0, 1) == 1) rrs[1:0] = 2'b00;
      run("rand", rop, rrs, $urandom,
          16'($urandom & 32'hFFFF_FFFC) |
            16'($urandom_range(0, 1) * 2),
          int'($urandom_range(0, TO)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
